// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - producer/FIFO-write-side signal bundle for fifo_wr_arbiter
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic                          fifo_full;
  logic [NUM_REQ-1:0]            grant;
  logic [NUM_REQ-1:0]            ack;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_data_in;
  logic                          busy;
  logic [ID_W-1:0]               owner_id;

  modport master (
    input  req, req_data, fifo_full,
    output grant, ack, fifo_wr_en, fifo_data_in, busy, owner_id
  );

  modport slave (
    output req, req_data, fifo_full,
    input  grant, ack, fifo_wr_en, fifo_data_in, busy, owner_id
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter sharing one FIFO write port
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 8
) (
  input  logic              clk,
  input  logic              rst,
  fifo_wr_arbiter_if.master bus
);
  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(BURST_LEN) + 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [ID_W-1:0]    owner_q, owner_d;
  logic               busy_q, busy_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;

  logic [ID_W-1:0]    sel;
  logic               sel_vld;
  logic [ID_W:0]      idx;
  logic               beat;
  logic               last_beat;
  logic [ID_W-1:0]    next_ptr;

  // First asserted request at or above rr_ptr, wrapping around.
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(NUM_REQ)) begin
        idx = idx - (ID_W+1)'(NUM_REQ);
      end
      if (!sel_vld && bus.req[idx[ID_W-1:0]]) begin
        sel     = idx[ID_W-1:0];
        sel_vld = 1'b1;
      end
    end
  end

  // A word offered while reset is asserted must not reach the FIFO.
  assign beat      = (state_q == BURST) && bus.req[owner_q] && !bus.fifo_full && !rst;
  assign last_beat = beat && (beat_cnt_q == CNT_W'(BURST_LEN - 1));
  assign next_ptr  = (owner_q == ID_W'(NUM_REQ - 1)) ? '0 : owner_q + ID_W'(1);

  always_comb begin
    bus.fifo_data_in = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == ID_W'(i)) begin
        bus.fifo_data_in = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign bus.grant      = grant_q;
  assign bus.ack        = grant_q & {NUM_REQ{beat}};
  assign bus.fifo_wr_en = beat;
  assign bus.busy       = busy_q;
  assign bus.owner_id   = owner_q;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    owner_d    = owner_q;
    busy_d     = busy_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (sel_vld) begin
          grant_d      = '0;
          grant_d[sel] = 1'b1;
          owner_d      = sel;
          busy_d       = 1'b1;
          beat_cnt_d   = '0;
          state_d      = BURST;
        end
      end
      BURST: begin
        // Release and completion both hand priority to the next index.
        if (!bus.req[owner_q] || last_beat) begin
          grant_d    = '0;
          owner_d    = '0;
          busy_d     = 1'b0;
          beat_cnt_d = '0;
          rr_ptr_d   = next_ptr;
          state_d    = IDLE;
        end else if (beat) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      owner_q    <= '0;
      busy_q     <= 1'b0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      owner_q    <= owner_d;
      busy_q     <= busy_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write arbiter that shares one synchronous FIFO write port among NUM_REQ producers.
- Grants one producer at a time for a burst of up to BURST_LEN words.
- Drives the FIFO write enable and write data, and back-pressures every producer when the FIFO reports full.
- Sits directly in front of the FIFO write side; the FIFO's full flag is its only feedback.

Parameters:
- NUM_REQ, 4, number of producers (>= 2).
- DATA_WIDTH, 32, FIFO word width.
- BURST_LEN, 8, maximum beats per grant (>= 1).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-producer request; bit i high = producer i has a word on req_data.
- req_data  input  NUM_REQ*DATA_WIDTH  producer i word in bits [i*DATA_WIDTH +: DATA_WIDTH].
- fifo_full  input  1  FIFO full flag.
- grant  output  NUM_REQ  registered one-hot owner; all-zero when idle.
- ack  output  NUM_REQ  combinational; ack[i] high = producer i's word is written this cycle.
- fifo_wr_en  output  1  FIFO write enable.
- fifo_data_in  output  DATA_WIDTH  FIFO write data.
- busy  output  1  registered; high while a burst is owned.
- owner_id  output  clog2(NUM_REQ)  registered index of the current owner; 0 when idle.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous, active-high.
- Reset values: state IDLE, grant=0, busy=0, owner_id=0, rr_ptr=0, beat_cnt=0. fifo_wr_en=0 and ack=0 follow because they are derived from grant.
- Reset wins over every other event, including mid-burst. A word presented in the reset cycle is not written.
- State IDLE:
  - If req != 0, select the first asserted req bit scanning upward from rr_ptr, wrapping modulo NUM_REQ.
  - Register grant = onehot(sel), owner_id = sel, busy = 1, beat_cnt = 0, then go to BURST.
  - No write occurs in an IDLE cycle.
- State BURST, write condition: beat = req[owner_id] & !fifo_full.
  - fifo_wr_en = beat.
  - fifo_data_in = req_data slice of owner_id, muxed combinationally. Its value is don't-care when fifo_wr_en=0, but the bench checks it only when fifo_wr_en=1.
  - ack[owner_id] = beat; all other ack bits are 0.
- State BURST, exit conditions:
  - Burst complete: beat && beat_cnt == BURST_LEN-1. This cycle's word is written, then exit.
  - Release: req[owner_id] == 0. No write, then exit.
- On exit: grant=0, busy=0, owner_id=0, rr_ptr=(owner+1) mod NUM_REQ, go to IDLE.
- Otherwise, on a beat: beat_cnt += 1. Width is clog2(BURST_LEN)+1 bits and it never wraps within a burst.
- fifo_full during BURST: stall. No write and no ack; beat_cnt, grant and state hold. There is no timeout.
- Latency:
  - req asserted in an IDLE cycle -> grant in the next cycle -> earliest write in that same cycle.
  - Re-arbitration costs exactly one IDLE cycle between bursts.
- Fairness: after a completed or released burst, the previous owner has the lowest priority in the next arbitration. A lone requester is re-granted after one IDLE cycle.
- Requests from non-owners during BURST are ignored, not queued. Selection uses the req value in the IDLE cycle only.
- Producer contract: hold req and data stable until ack. The arbiter does not check this.
- Invariants:
  - grant is one-hot or zero.
  - fifo_wr_en implies !fifo_full.
  - popcount(ack) <= 1.
  - ack == grant & {NUM_REQ{fifo_wr_en}}.

Test Plan:
1. Reset, then only req[2] high, data 0xA0..0xA9 on successive acks, BURST_LEN=8, fifo_full=0 -> grant=0100 one cycle later. Eight writes 0xA0..0xA7, one IDLE cycle (grant=0), re-grant to 2, writes 0xA8, 0xA9.
2. req=1111 constantly, fifo_full=0 -> owners in order 0,1,2,3,0. Each owns 8 consecutive writes with a 1-cycle gap, so 36 cycles per round.
3. Owner 1 at beat 3, fifo_full raised for 5 cycles -> fifo_wr_en=0, ack=0, grant=0010 held. Beats resume at beat_cnt=3, with 8 words total for the burst.
4. Owner 0 drops req after 2 beats while req[3] is high -> exit with 2 words written, IDLE one cycle, then grant=1000, rr_ptr=1.
5. rst asserted mid-burst (owner 2, beat 5, req high) -> next cycle grant=0, busy=0, no write in the reset cycle. After release with req=1111, the first grant goes to 0.
6. Random req/fifo_full for 10k cycles, scoreboard per producer -> invariants never violated, and FIFO word order matches per-producer ack order.
